set_assoc_tag_lookup: RTL and testbench
=======================================

# set_assoc_tag_lookup

Parametrised N-way set-associative tag directory for the accelerator's weight/activation cache. It splits a request address into tag, set index and block offset, and compares the tag against every way of the selected set. One cycle later it returns hit/miss, the hit way and a victim way. It also accepts tag fills from the refill path and supports a multi-cycle invalidate-all flush. It sits between the cache controller request port and the data array.

## Interface
- TAG_WIDTH, 13, tag bits
- SET_WIDTH, 8, set index bits; 2**SET_WIDTH sets
- OFFSET_WIDTH, 2, block offset bits (LSBs of address)
- WAYS, 4, associativity; power of two, ≥2; WAY_W = $clog2(WAYS)
- ADDR_W (local), TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when req_valid && req_ready
- req_address  in  ADDR_W  lookup address
- resp_valid  out  1  one-cycle result strobe, no backpressure
- resp_hit  out  1  tag matched a valid way
- resp_way  out  WAY_W  hit way on hit, victim way on miss
- resp_tag / resp_set / resp_offset  out  TAG_WIDTH / SET_WIDTH / OFFSET_WIDTH  decoded fields of accepted address
- fill_valid  in  1  write tag into directory
- fill_ready  out  1  = !busy
- fill_address  in  ADDR_W  address being filled (offset ignored)
- fill_way  in  WAY_W  way to write
- flush_req  in  1  start invalidate-all
- busy  out  1  flush in progress

## Operation
- Field split: tag = addr[ADDR_W-1 -: TAG_WIDTH], set = addr[OFFSET_WIDTH +: SET_WIDTH], offset = addr[OFFSET_WIDTH-1:0].
- Storage: tag[set][way] (no reset); valid[set][way] flops cleared by rst_n; rr_ptr[set] (WAY_W bits, reset 0).
- Lookup: at acceptance, compare against all ways; register hit, way, fields. Multiple matches (illegal) resolve to the lowest index.
- Victim: the lowest-index invalid way in the set; if all ways are valid, rr_ptr[set].
- Fill (fill_valid && fill_ready): tag[set][fill_way] ← tag, valid ← 1, rr_ptr[set] ← fill_way+1 mod WAYS. Filling a valid way overwrites it.
- req_ready = !busy && !fill_valid. A fill has priority, so lookup and fill never share a cycle.
- FSM IDLE/FLUSH, reset to IDLE.
  - IDLE: flush_req → FLUSH, counter ← 0.
  - FLUSH: clear valid[counter][*] and rr_ptr[counter], then counter++. After set 2**SET_WIDTH-1, go to IDLE.
  - flush_req while in FLUSH is ignored.
- Reset mid-flush: return to IDLE immediately with all valid bits cleared.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, resp_tag/set/offset=0, fill_ready=1, busy=0.
- Lookup latency is 1 cycle: accept at edge N, resp_* valid during cycle N+1. Throughput is 1 lookup per cycle.
- A fill at edge N is visible to a lookup accepted at edge N+1 or later.
- busy rises the cycle after flush_req is sampled and stays high exactly 2**SET_WIDTH cycles. req_ready and fill_ready are low for that whole window.
- resp_valid is deasserted in any cycle without a prior acceptance.

## Structure
- Package cache_pkg holds:
  - the FSM state enum (ST_IDLE, ST_FLUSH)
  - default parameter constants
  - a function that computes the first invalid way index
- Sub-module way_victim_select: combinational; takes the valid vector and rr_ptr and outputs the victim way. Parametrised by WAYS.
- Top module: storage, comparators, FSM, output registers.

## Test plan
- Reset, then lookup addr 0x0001234 → resp_valid next cycle, hit=0, way=0, set/offset fields match the split.
- Fill set 5, tag 0x1AB, way 2, then lookup the same tag/set with offset 3 → hit=1, way=2, resp_offset=3.
- Fill all 4 ways of set 7 in order 0,1,2,3 (rr_ptr→0), then miss lookup → hit=0, way=0. Fill way 0 again, then miss → way=1.
- Back-to-back lookups on 3 consecutive cycles → 3 consecutive resp_valid, results in order. Assert fill_valid in the middle cycle → req_ready=0 that cycle, and the fill is visible to the following lookup.
- flush_req after fills → busy high exactly 256 cycles, req_ready=0 throughout, and a prior hit address then misses with victim way 0.
- Assert rst_n low at flush counter 100 → outputs return to reset values, busy=0, and all lookups miss.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, defaults and helpers for the set-associative tag directory.
// Holds the flush FSM encoding and the first-invalid-way search.
package cache_pkg;

  localparam int TAG_WIDTH_DEF    = 13;
  localparam int SET_WIDTH_DEF    = 8;
  localparam int OFFSET_WIDTH_DEF = 2;
  localparam int WAYS_DEF         = 4;
  localparam int MAX_WAYS         = 64;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_e;

  // Lowest index i < ways with v[i] == 0; returns ways if none.
  function automatic int first_invalid(
    input logic [MAX_WAYS-1:0] v,
    input int                  ways
  );
    int idx;
    idx = ways;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (i < ways && !v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/way_victim_select.sv
// Victim way picker: lowest invalid way, else the set's round-robin pointer.
// Ports: valid (per-way valid bits), rr_ptr (set pointer), victim (way index).
module way_victim_select
  import cache_pkg::*;
#(
  parameter  int WAYS  = WAYS_DEF,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim
);

  logic [MAX_WAYS-1:0] v_ext;
  int                  idx;

  always_comb begin
    v_ext = '1;
    for (int i = 0; i < WAYS; i++) v_ext[i] = valid[i];
    idx = first_invalid(v_ext, WAYS);
    if (idx < WAYS) victim = WAY_W'(idx);
    else            victim = rr_ptr;
  end

endmodule

// File: rtl/set_assoc_tag_lookup.sv
// N-way tag directory: 1-cycle lookup with hit/victim, fills, flush-all FSM.
// Ports: req_* lookup in, resp_* result out, fill_* tag writes, flush_req/busy.
module set_assoc_tag_lookup
  import cache_pkg::*;
#(
  parameter  int TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter  int SET_WIDTH    = SET_WIDTH_DEF,
  parameter  int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter  int WAYS         = WAYS_DEF,
  localparam int WAY_W        = $clog2(WAYS),
  localparam int ADDR_W       = TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_address,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [WAY_W-1:0]        resp_way,
  output logic [TAG_WIDTH-1:0]    resp_tag,
  output logic [SET_WIDTH-1:0]    resp_set,
  output logic [OFFSET_WIDTH-1:0] resp_offset,
  input  logic                    fill_valid,
  output logic                    fill_ready,
  input  logic [ADDR_W-1:0]       fill_address,
  input  logic [WAY_W-1:0]        fill_way,
  input  logic                    flush_req,
  output logic                    busy
);

  localparam int SETS = 2 ** SET_WIDTH;

  logic [TAG_WIDTH-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [WAY_W-1:0]     rr_q    [SETS];
  logic [WAY_W-1:0]     rr_d    [SETS];

  state_e               state_q, state_d;
  logic [SET_WIDTH-1:0] cnt_q, cnt_d;

  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]        resp_way_q, resp_way_d;
  logic [TAG_WIDTH-1:0]    resp_tag_q, resp_tag_d;
  logic [SET_WIDTH-1:0]    resp_set_q, resp_set_d;
  logic [OFFSET_WIDTH-1:0] resp_off_q, resp_off_d;

  logic [TAG_WIDTH-1:0]    req_tag, fill_tag;
  logic [SET_WIDTH-1:0]    req_set, fill_set;
  logic [OFFSET_WIDTH-1:0] req_off;
  logic                    req_fire, fill_fire;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way, victim;
  logic                    unused_fill_off;

  assign req_tag  = req_address[ADDR_W-1 -: TAG_WIDTH];
  assign req_set  = req_address[OFFSET_WIDTH +: SET_WIDTH];
  assign req_off  = req_address[OFFSET_WIDTH-1:0];
  assign fill_tag = fill_address[ADDR_W-1 -: TAG_WIDTH];
  assign fill_set = fill_address[OFFSET_WIDTH +: SET_WIDTH];
  assign unused_fill_off = ^fill_address[OFFSET_WIDTH-1:0];

  assign busy       = (state_q == ST_FLUSH);
  assign fill_ready = !busy;
  assign req_ready  = !busy && !fill_valid;
  assign req_fire   = req_valid && req_ready;
  assign fill_fire  = fill_valid && fill_ready;

  // Ascending scan with a found flag so duplicates pick the lowest way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_set][w] &&
          tag_mem[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  way_victim_select #(
    .WAYS(WAYS)
  ) u_victim (
    .valid (valid_q[req_set]),
    .rr_ptr(rr_q[req_set]),
    .victim(victim)
  );

  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        valid_d[cnt_q] = '0;
        rr_d[cnt_q]    = '0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == SET_WIDTH'(SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // WAYS is a power of two, so the add wraps naturally.
    if (fill_fire) begin
      valid_d[fill_set][fill_way] = 1'b1;
      rr_d[fill_set]              = fill_way + WAY_W'(1);
    end
  end

  always_comb begin
    resp_valid_d = req_fire;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_tag_d   = resp_tag_q;
    resp_set_d   = resp_set_q;
    resp_off_d   = resp_off_q;
    if (req_fire) begin
      resp_hit_d = hit;
      resp_way_d = hit ? hit_way : victim;
      resp_tag_d = req_tag;
      resp_set_d = req_set;
      resp_off_d = req_off;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_fire) tag_mem[fill_set][fill_way] <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_tag_q   <= '0;
      resp_set_q   <= '0;
      resp_off_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_tag_q   <= resp_tag_d;
      resp_set_q   <= resp_set_d;
      resp_off_q   <= resp_off_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_way    = resp_way_q;
  assign resp_tag    = resp_tag_q;
  assign resp_set    = resp_set_q;
  assign resp_offset = resp_off_q;

endmodule

// File: tb/tb_set_assoc_tag_lookup.sv
// Directed bench for set_assoc_tag_lookup: vector table plus flush/reset runs.
// Default parameters: 13-bit tag, 8-bit set, 2-bit offset, 4 ways.
module tb_set_assoc_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [22:0] req_address = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [12:0] resp_tag;
  logic [7:0]  resp_set;
  logic [1:0]  resp_offset;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [22:0] fill_address = '0;
  logic [1:0]  fill_way = '0;
  logic        flush_req = 1'b0;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  set_assoc_tag_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_tag(resp_tag),
    .resp_set(resp_set), .resp_offset(resp_offset),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_address(fill_address), .fill_way(fill_way),
    .flush_req(flush_req), .busy(busy)
  );

  typedef struct {
    bit          is_fill;
    logic [12:0] tag;
    logic [7:0]  set;
    logic [1:0]  off;
    logic [1:0]  way;
    bit          exp_hit;
    logic [1:0]  exp_way;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [22:0] mk(input logic [12:0] t,
                                     input logic [7:0] s,
                                     input logic [1:0] o);
    return {t, s, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    fill_valid = 1'b0;
    flush_req  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic lookup(input logic [12:0] t, input logic [7:0] s,
                        input logic [1:0] o);
    req_valid   = 1'b1;
    req_address = mk(t, s, o);
    tick();
  endtask

  task automatic fill(input logic [12:0] t, input logic [7:0] s,
                      input logic [1:0] w);
    fill_valid   = 1'b1;
    fill_address = mk(t, s, 2'd0);
    fill_way     = w;
    tick();
  endtask

  task automatic check_resp(input string n, input logic [12:0] t,
                            input logic [7:0] s, input logic [1:0] o,
                            input bit h, input logic [1:0] w);
    chk({n, ".valid"}, 32'(resp_valid), 32'd1);
    chk({n, ".hit"}, 32'(resp_hit), 32'(h));
    chk({n, ".way"}, 32'(resp_way), 32'(w));
    chk({n, ".tag"}, 32'(resp_tag), 32'(t));
    chk({n, ".set"}, 32'(resp_set), 32'(s));
    chk({n, ".off"}, 32'(resp_offset), 32'(o));
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({n, ".fill_ready"}, 32'(fill_ready), 32'd1);
    chk({n, ".busy"}, 32'(busy), 32'd0);
    chk({n, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({n, ".resp_hit"}, 32'(resp_hit), 32'd0);
    chk({n, ".resp_way"}, 32'(resp_way), 32'd0);
    chk({n, ".resp_fields"},
        32'({resp_tag, resp_set, resp_offset}), 32'd0);
  endtask

  initial begin
    int  cnt;
    bit  rdy_ok;

    vecs[0]  = '{0, 13'h0004, 8'h8D, 2'd0, 2'd0, 0, 2'd0};
    vecs[1]  = '{1, 13'h01AB, 8'd5, 2'd0, 2'd2, 0, 2'd0};
    vecs[2]  = '{0, 13'h01AB, 8'd5, 2'd3, 2'd0, 1, 2'd2};
    vecs[3]  = '{1, 13'h0100, 8'd7, 2'd0, 2'd0, 0, 2'd0};
    vecs[4]  = '{1, 13'h0101, 8'd7, 2'd0, 2'd1, 0, 2'd0};
    vecs[5]  = '{1, 13'h0102, 8'd7, 2'd0, 2'd2, 0, 2'd0};
    vecs[6]  = '{1, 13'h0103, 8'd7, 2'd0, 2'd3, 0, 2'd0};
    vecs[7]  = '{0, 13'h01FF, 8'd7, 2'd1, 2'd0, 0, 2'd0};
    vecs[8]  = '{1, 13'h0104, 8'd7, 2'd0, 2'd0, 0, 2'd0};
    vecs[9]  = '{0, 13'h01FF, 8'd7, 2'd2, 2'd0, 0, 2'd1};
    vecs[10] = '{0, 13'h0101, 8'd7, 2'd0, 2'd0, 1, 2'd1};
    vecs[11] = '{0, 13'h0100, 8'd7, 2'd0, 2'd0, 0, 2'd1};
    vecs[12] = '{0, 13'h01AB, 8'd5, 2'd0, 2'd0, 1, 2'd2};
    vecs[13] = '{0, 13'h01AC, 8'd5, 2'd0, 2'd0, 0, 2'd0};
    vecs[14] = '{1, 13'h0055, 8'd9, 2'd0, 2'd1, 0, 2'd0};
    vecs[15] = '{0, 13'h0066, 8'd9, 2'd0, 2'd0, 0, 2'd0};
    vecs[16] = '{1, 13'h0066, 8'd9, 2'd0, 2'd0, 0, 2'd0};
    vecs[17] = '{0, 13'h0077, 8'd9, 2'd0, 2'd0, 0, 2'd2};
    vecs[18] = '{0, 13'h0066, 8'd9, 2'd1, 2'd0, 1, 2'd0};
    vecs[19] = '{1, 13'h1FFF, 8'd200, 2'd0, 2'd3, 0, 2'd0};

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_fill) begin
        fill(vecs[i].tag, vecs[i].set, vecs[i].way);
        chk($sformatf("v%0d.no_resp", i), 32'(resp_valid), 32'd0);
      end else begin
        lookup(vecs[i].tag, vecs[i].set, vecs[i].off);
        check_resp($sformatf("v%0d", i), vecs[i].tag, vecs[i].set,
                   vecs[i].off, vecs[i].exp_hit, vecs[i].exp_way);
      end
    end

    // Three back-to-back lookups, one response per cycle in order.
    lookup(13'h0101, 8'd7, 2'd0);
    check_resp("b2b0", 13'h0101, 8'd7, 2'd0, 1, 2'd1);
    lookup(13'h0102, 8'd7, 2'd1);
    check_resp("b2b1", 13'h0102, 8'd7, 2'd1, 1, 2'd2);
    lookup(13'h01AB, 8'd5, 2'd2);
    check_resp("b2b2", 13'h01AB, 8'd5, 2'd2, 1, 2'd2);

    // Fill in the middle cycle blocks the lookup and is seen next cycle.
    lookup(13'h0103, 8'd7, 2'd3);
    check_resp("mix0", 13'h0103, 8'd7, 2'd3, 1, 2'd3);
    req_valid    = 1'b1;
    req_address  = mk(13'h0022, 8'd11, 2'd0);
    fill_valid   = 1'b1;
    fill_address = mk(13'h0022, 8'd11, 2'd0);
    fill_way     = 2'd3;
    #1;
    chk("mix1.req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mix1.no_resp", 32'(resp_valid), 32'd0);
    lookup(13'h0022, 8'd11, 2'd1);
    check_resp("mix2", 13'h0022, 8'd11, 2'd1, 1, 2'd3);

    // Flush: busy for exactly 256 cycles with both readies low.
    flush_req = 1'b1;
    tick();
    chk("flush.busy_rise", 32'(busy), 32'd1);
    cnt    = 0;
    rdy_ok = 1'b1;
    while (busy && cnt < 400) begin
      cnt++;
      if (req_ready || fill_ready) rdy_ok = 1'b0;
      flush_req = 1'b1;
      tick();
    end
    chk("flush.len", 32'(cnt), 32'd256);
    chk("flush.ready_low", 32'(rdy_ok), 32'd1);
    chk("flush.ready_back", 32'(req_ready), 32'd1);
    lookup(13'h01AB, 8'd5, 2'd0);
    check_resp("postflush5", 13'h01AB, 8'd5, 2'd0, 0, 2'd0);
    lookup(13'h0101, 8'd7, 2'd0);
    check_resp("postflush7", 13'h0101, 8'd7, 2'd0, 0, 2'd0);

    // Reset in the middle of a flush, at counter 100.
    fill(13'h0101, 8'd7, 2'd1);
    fill(13'h1FFF, 8'd200, 2'd3);
    lookup(13'h1FFF, 8'd200, 2'd0);
    check_resp("prerst200", 13'h1FFF, 8'd200, 2'd0, 1, 2'd3);
    flush_req = 1'b1;
    tick();
    chk("rstflush.busy", 32'(busy), 32'd1);
    repeat (100) tick();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.idle", 32'(busy), 32'd0);
    lookup(13'h0101, 8'd7, 2'd0);
    check_resp("midrst7", 13'h0101, 8'd7, 2'd0, 0, 2'd0);
    lookup(13'h1FFF, 8'd200, 2'd0);
    check_resp("midrst200", 13'h1FFF, 8'd200, 2'd0, 0, 2'd0);
    tick();
    chk("idle.no_resp", 32'(resp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
